// File: rtl/c_seq_arbiter.sv
// ---------------------------------------------------------------------------
// c_seq_arbiter
// Round-robin arbiter/sequencer that shares one Gold-sequence generator
// (c_seq_gen_control) between NREQ requesters. The winner's c_init, threshold
// and word count are latched, the generator is started, and the generator's
// NGEN-bit word stream is forwarded to the granted requester under its get
// handshake until the requested number of words has been delivered.
//
// Optional feature macro: C_SEQ_ARB_TIMEOUT_EN
//   When defined, an o_timeout output and a WAIT-state watchdog are added. If
//   no m_valid is seen TIMEOUT cycles after m_start, the transaction is
//   closed with a normal s_done pulse and o_timeout is set sticky.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   s_req         : per-requester request level (sampled only in IDLE)
//   s_init        : per-requester 31-bit c_init, slice k = [31k+30:31k]
//   s_threshold   : per-requester 16-bit generator threshold
//   s_len         : per-requester word count (LEN_W bits each)
//   s_get         : per-requester word pull
//   s_grant       : one-hot grant, START through DONE
//   s_valid       : word available to the granted requester
//   s_data        : word broadcast, meaningful only with s_valid
//   s_done        : one-cycle completion pulse
//   m_start       : generator start pulse
//   m_init        : generator c_init
//   m_threshold   : generator threshold
//   m_get         : generator pull
//   m_gen_bit     : generator word
//   m_valid       : generator word valid
//   o_timeout     : (C_SEQ_ARB_TIMEOUT_EN only) sticky WAIT timeout flag
// ---------------------------------------------------------------------------
module c_seq_arbiter #(
   parameter int NREQ    = 2,
   parameter int NGEN    = 2,
   parameter int LEN_W   = 10,
   parameter int TIMEOUT = 4095
) (
`ifdef C_SEQ_ARB_TIMEOUT_EN
   output logic                  o_timeout,
`endif
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       s_req,
   input  logic [NREQ*31-1:0]    s_init,
   input  logic [NREQ*16-1:0]    s_threshold,
   input  logic [NREQ*LEN_W-1:0] s_len,
   input  logic [NREQ-1:0]       s_get,
   output logic [NREQ-1:0]       s_grant,
   output logic [NREQ-1:0]       s_valid,
   output logic [NGEN-1:0]       s_data,
   output logic [NREQ-1:0]       s_done,
   output logic                  m_start,
   output logic [30:0]           m_init,
   output logic [15:0]           m_threshold,
   output logic                  m_get,
   input  logic [NGEN-1:0]       m_gen_bit,
   input  logic                  m_valid
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_WAIT   = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_ptr;
   logic [30:0]      r_init;
   logic [15:0]      r_thr;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;

   logic [30:0]      w_init_arr [NREQ];
   logic [15:0]      w_thr_arr  [NREQ];
   logic [LEN_W-1:0] w_len_arr  [NREQ];

   logic             w_sel_found;
   logic [IDX_W-1:0] w_sel_idx;
   logic [IDX_W:0]   w_rr_sum;
   logic [IDX_W-1:0] w_rr_cand;
   logic [NREQ-1:0]  w_onehot;
   logic             w_get;
   logic             w_timeout_hit;

   // Unpack the flat per-requester buses into indexable arrays.
   for (genvar k = 0; k < NREQ; k++) begin : g_slice
      assign w_init_arr[k] = s_init[31*k +: 31];
      assign w_thr_arr[k]  = s_threshold[16*k +: 16];
      assign w_len_arr[k]  = s_len[LEN_W*k +: LEN_W];
   end

   assign w_onehot    = NREQ'(1) << r_idx;
   assign w_get       = (r_state == S_STREAM) && m_valid && s_get[r_idx];
   assign m_init      = r_init;
   assign m_threshold = r_thr;

   // Round-robin pick: first set request at or after the pointer, wrapping.
   // Scanning offsets high-to-low lets the smallest offset win.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      w_rr_sum    = '0;
      w_rr_cand   = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         w_rr_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
         if (w_rr_sum >= (IDX_W+1)'(NREQ)) begin
            w_rr_sum = w_rr_sum - (IDX_W+1)'(NREQ);
         end else begin
            w_rr_sum = w_rr_sum;
         end
         w_rr_cand = w_rr_sum[IDX_W-1:0];
         if (s_req[w_rr_cand]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = w_rr_cand;
         end else begin
            w_sel_found = w_sel_found;
         end
      end
   end

`ifdef C_SEQ_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] r_tcnt;

   // Watchdog fires on the cycle that would be the TIMEOUT-th after m_start.
   assign w_timeout_hit = (r_state == S_WAIT) && !m_valid &&
                          (r_tcnt >= TO_W'(TIMEOUT - 1));

   // Cycles-since-m_start counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt    <= '0;
         o_timeout <= 1'b0;
      end else begin
         if (r_state == S_START) begin
            r_tcnt <= TO_W'(1);
         end else if (r_state == S_WAIT) begin
            r_tcnt <= r_tcnt + TO_W'(1);
         end else begin
            r_tcnt <= r_tcnt;
         end
         if (w_timeout_hit) begin
            o_timeout <= 1'b1;
         end else begin
            o_timeout <= o_timeout;
         end
      end
   end
`else
   // Gives TIMEOUT a reader in the build without the watchdog.
   localparam int unused_timeout = TIMEOUT;
   assign w_timeout_hit = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_sel_found) begin
               if (w_len_arr[w_sel_idx] == '0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_START;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_START: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (m_valid) begin
               w_state_nxt = S_STREAM;
            end else if (w_timeout_hit) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_STREAM: begin
            if (w_get && (r_cnt == (r_len - LEN_W'(1)))) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_STREAM;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode; STREAM is a combinational pass-through of the generator.
   always_comb begin
      s_grant = '0;
      s_valid = '0;
      s_data  = '0;
      s_done  = '0;
      m_start = 1'b0;
      m_get   = 1'b0;
      case (r_state)
         S_IDLE: s_grant = '0;
         S_START: begin
            s_grant = w_onehot;
            m_start = 1'b1;
         end
         S_WAIT: s_grant = w_onehot;
         S_STREAM: begin
            s_grant = w_onehot;
            s_valid = m_valid ? w_onehot : '0;
            s_data  = m_gen_bit;
            m_get   = w_get;
         end
         S_DONE: begin
            s_grant = w_onehot;
            s_done  = w_onehot;
         end
         default: s_grant = '0;
      endcase
   end

   // State register, latched transaction parameters, word count and pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_init  <= '0;
         r_thr   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_sel_found) begin
                  r_idx  <= w_sel_idx;
                  r_init <= w_init_arr[w_sel_idx];
                  r_thr  <= w_thr_arr[w_sel_idx];
                  r_len  <= w_len_arr[w_sel_idx];
                  r_cnt  <= '0;
               end else begin
                  r_idx  <= r_idx;
               end
            end
            S_STREAM: begin
               if (w_get) begin
                  r_cnt <= r_cnt + LEN_W'(1);
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            S_DONE: begin
               r_ptr <= (r_idx == IDX_W'(NREQ - 1)) ? '0 : (r_idx + IDX_W'(1));
            end
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_c_seq_arbiter.sv
module tb_c_seq_arbiter;

   localparam int NREQ  = 2;
   localparam int NGEN  = 2;
   localparam int LEN_W = 10;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       s_req;
   logic [NREQ*31-1:0]    s_init;
   logic [NREQ*16-1:0]    s_threshold;
   logic [NREQ*LEN_W-1:0] s_len;
   logic [NREQ-1:0]       s_get;
   logic [NREQ-1:0]       s_grant;
   logic [NREQ-1:0]       s_valid;
   logic [NGEN-1:0]       s_data;
   logic [NREQ-1:0]       s_done;
   logic                  m_start;
   logic [30:0]           m_init;
   logic [15:0]           m_threshold;
   logic                  m_get;
   logic [NGEN-1:0]       m_gen_bit;
   logic                  m_valid;
`ifdef C_SEQ_ARB_TIMEOUT_EN
   logic                  o_timeout;
`endif

   c_seq_arbiter #(.NREQ(NREQ), .NGEN(NGEN), .LEN_W(LEN_W), .TIMEOUT(4095)) dut (
`ifdef C_SEQ_ARB_TIMEOUT_EN
      .o_timeout   (o_timeout),
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .s_req       (s_req),
      .s_init      (s_init),
      .s_threshold (s_threshold),
      .s_len       (s_len),
      .s_get       (s_get),
      .s_grant     (s_grant),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_done      (s_done),
      .m_start     (m_start),
      .m_init      (m_init),
      .m_threshold (m_threshold),
      .m_get       (m_get),
      .m_gen_bit   (m_gen_bit),
      .m_valid     (m_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference state
   int               ptr = 0;
   logic [30:0]      p_init [NREQ];
   logic [15:0]      p_thr  [NREQ];
   logic [LEN_W-1:0] p_len  [NREQ];
   bit               rnd_params = 1'b0;
   bit               get_all    = 1'b1;
   logic [NGEN-1:0]  gen_word   = '0;
   bit               pulled     = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] req, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (req[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] rand_req();
      logic [NREQ-1:0] r;
      r = NREQ'($urandom);
      return r;
   endfunction

   // Drive one cycle of inputs (called just after a rising edge).
   task automatic drive(input logic [NREQ-1:0] req);
      if (pulled) gen_word = NGEN'($urandom);
      pulled = 1'b0;
      if (rnd_params) begin
         for (int k = 0; k < NREQ; k++) begin
            p_init[k] = 31'($urandom);
            p_thr[k]  = 16'($urandom);
            p_len[k]  = LEN_W'($urandom_range(0, 12));
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         s_init[31*k +: 31]        = p_init[k];
         s_threshold[16*k +: 16]   = p_thr[k];
         s_len[LEN_W*k +: LEN_W]   = p_len[k];
      end
      s_req     = req;
      s_get     = get_all ? {NREQ{1'b1}} : NREQ'($urandom);
      m_valid   = ($urandom_range(0, 3) != 0);
      m_gen_bit = gen_word;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_grant"}, 64'(s_grant), 64'd0);
      chk({tag, "_valid"}, 64'(s_valid), 64'd0);
      chk({tag, "_data"},  64'(s_data),  64'd0);
      chk({tag, "_done"},  64'(s_done),  64'd0);
      chk({tag, "_start"}, 64'(m_start), 64'd0);
      chk({tag, "_init"},  64'(m_init),  64'd0);
      chk({tag, "_thr"},   64'(m_threshold), 64'd0);
      chk({tag, "_mget"},  64'(m_get),   64'd0);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      s_req   = '0;
      s_get   = '0;
      m_valid = 1'b0;
      @(negedge clk);
      chk_zero("rst");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      ptr    = 0;
      pulled = 1'b0;
   endtask

   // One arbitration plus the whole resulting transaction.
   task automatic run_txn(input logic [NREQ-1:0] req, input int abort_at, output int w);
      logic [NREQ-1:0]  oh;
      logic [30:0]      e_init;
      logic [15:0]      e_thr;
      int               e_len;
      int               n;
      int               cyc;
      bit               seen;
      logic             e_get;
      drive(req);
      @(negedge clk);
      chk("idle_grant", 64'(s_grant), 64'd0);
      chk("idle_start", 64'(m_start), 64'd0);
      chk("idle_done",  64'(s_done),  64'd0);
      w      = rr_pick(req, ptr);
      oh     = NREQ'(1) << w;
      e_init = p_init[w];
      e_thr  = p_thr[w];
      e_len  = int'(p_len[w]);
      tick();
      if (e_len != 0) begin
         drive(rand_req());
         @(negedge clk);
         chk("st_start", 64'(m_start), 64'd1);
         chk("st_grant", 64'(s_grant), 64'(oh));
         chk("st_init",  64'(m_init),  64'(e_init));
         chk("st_thr",   64'(m_threshold), 64'(e_thr));
         chk("st_valid", 64'(s_valid), 64'd0);
         tick();
         seen = 1'b0;
         cyc  = 0;
         while (!seen && cyc < 200) begin
            drive(rand_req());
            @(negedge clk);
            chk("wt_grant", 64'(s_grant), 64'(oh));
            chk("wt_start", 64'(m_start), 64'd0);
            chk("wt_valid", 64'(s_valid), 64'd0);
            chk("wt_mget",  64'(m_get),   64'd0);
            seen   = m_valid;
            pulled = m_get;
            tick();
            cyc++;
         end
         if (!seen) chk("wait_bound", 64'd0, 64'd1);
         n   = 0;
         cyc = 0;
         while (n < e_len && cyc < 400) begin
            drive(rand_req());
            @(negedge clk);
            e_get = m_valid & s_get[w];
            chk("sm_grant", 64'(s_grant), 64'(oh));
            chk("sm_valid", 64'(s_valid), m_valid ? 64'(oh) : 64'd0);
            chk("sm_mget",  64'(m_get),   64'(e_get));
            chk("sm_done",  64'(s_done),  64'd0);
            chk("sm_init",  64'(m_init),  64'(e_init));
            chk("sm_thr",   64'(m_threshold), 64'(e_thr));
            if (m_valid) chk("sm_data", 64'(s_data), 64'(gen_word));
            pulled = m_get;
            if (e_get) n++;
            if (abort_at >= 0 && n == abort_at) begin
               #2;
               rst_n = 1'b0;
               #1;
               chk_zero("abort");
               s_req = '0;
               @(posedge clk);
               #1;
               chk("abort_done", 64'(s_done), 64'd0);
               #2;
               rst_n = 1'b1;
               tick();
               ptr    = 0;
               pulled = 1'b0;
               return;
            end
            tick();
            cyc++;
         end
         if (n < e_len) chk("stream_bound", 64'(n), 64'(e_len));
      end
      drive(rand_req());
      @(negedge clk);
      chk("dn_done",  64'(s_done),  64'(oh));
      chk("dn_grant", 64'(s_grant), 64'(oh));
      chk("dn_start", 64'(m_start), 64'd0);
      chk("dn_mget",  64'(m_get),   64'd0);
      chk("dn_valid", 64'(s_valid), 64'd0);
      tick();
      ptr = (w + 1) % NREQ;
   endtask

   initial begin
      int w;
      logic [NREQ-1:0] r;
      s_init = '0; s_threshold = '0; s_len = '0; m_gen_bit = '0;
      for (int k = 0; k < NREQ; k++) begin
         p_init[k] = '0; p_thr[k] = '0; p_len[k] = '0;
      end
      do_reset();

      // single requester 0, long transfer
      p_init[0] = {16'd56789, 5'd0, 10'd512};
      p_thr[0]  = 16'd0;
      p_len[0]  = LEN_W'(100);
      run_txn(2'b01, -1, w);
      chk("t1_winner", 64'(w), 64'd0);

      // simultaneous requests after reset: strict alternation 0,1,0,1
      do_reset();
      p_init[1] = 31'h1234567;
      p_thr[1]  = 16'hbeef;
      p_len[0]  = LEN_W'(14);
      p_len[1]  = LEN_W'(14);
      get_all   = 1'b0;
      for (int t = 0; t < 4; t++) begin
         run_txn(2'b11, -1, w);
         chk("rr_order", 64'(w), 64'(t % 2));
      end

      // zero-length request from requester 1, then pointer wraps to 0
      p_len[1] = '0;
      run_txn(2'b10, -1, w);
      chk("len0_winner", 64'(w), 64'd1);
      run_txn(2'b11, -1, w);
      chk("len0_next", 64'(w), 64'd0);

      // reset during streaming, then a fresh full transfer
      do_reset();
      p_len[0] = LEN_W'(42);
      run_txn(2'b01, 5, w);
      run_txn(2'b01, -1, w);
      chk("post_abort", 64'(w), 64'd0);

      // randomized traffic
      rnd_params = 1'b1;
      for (int t = 0; t < 40; t++) begin
         do r = rand_req(); while (r == '0);
         run_txn(r, -1, w);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
